// File: rtl/mul_reservation_station_if.sv
// ---------------------------------------------------------------------------
// mul_reservation_station_if
//
// Bundles every non-clock/reset signal of the M-extension reservation station:
// dispatch handshake and operands, CDB snoop, flush, the issue bus that feeds
// the MUL/DIV control unit, the unit's busy flag and the occupancy count.
//
// Modports:
//   slave  - the reservation station (consumes dispatch/CDB/busy, drives issue)
//   master - the surrounding pipeline (drives dispatch/CDB/busy, observes issue)
// ---------------------------------------------------------------------------
interface mul_reservation_station_if #(
    parameter int ROBSIZE = 8,
    parameter int DEPTH   = 4
);
    // Pipeline control
    logic                         i_flush;

    // Dispatch
    logic                         i_disp_valid;
    logic                         o_disp_ready;
    logic [ROBSIZE-1:0]           i_disp_rob_addr;
    logic [2:0]                   i_disp_opcode;
    logic                         i_disp_rs1_ready;
    logic                         i_disp_rs2_ready;
    logic [31:0]                  i_disp_rs1_value;
    logic [31:0]                  i_disp_rs2_value;
    logic [ROBSIZE-1:0]           i_disp_rs1_tag;
    logic [ROBSIZE-1:0]           i_disp_rs2_tag;

    // Common data bus snoop
    logic                         i_cdb_valid;
    logic [ROBSIZE-1:0]           i_cdb_rob_addr;
    logic [31:0]                  i_cdb_value;

    // Issue to the MUL/DIV control unit
    logic                         i_eu_busy;
    logic                         o_ex_en;
    logic [ROBSIZE-1:0]           o_rob_addr;
    logic [31:0]                  o_rs1_value;
    logic [31:0]                  o_rs2_value;
    logic [2:0]                   o_alu_m_opcode;

    // Occupancy
    logic [$clog2(DEPTH+1)-1:0]   o_count;

    modport slave (
        input  i_flush,
        input  i_disp_valid, i_disp_rob_addr, i_disp_opcode,
        input  i_disp_rs1_ready, i_disp_rs2_ready,
        input  i_disp_rs1_value, i_disp_rs2_value,
        input  i_disp_rs1_tag, i_disp_rs2_tag,
        input  i_cdb_valid, i_cdb_rob_addr, i_cdb_value,
        input  i_eu_busy,
        output o_disp_ready,
        output o_ex_en, o_rob_addr, o_rs1_value, o_rs2_value, o_alu_m_opcode,
        output o_count
    );

    modport master (
        output i_flush,
        output i_disp_valid, i_disp_rob_addr, i_disp_opcode,
        output i_disp_rs1_ready, i_disp_rs2_ready,
        output i_disp_rs1_value, i_disp_rs2_value,
        output i_disp_rs1_tag, i_disp_rs2_tag,
        output i_cdb_valid, i_cdb_rob_addr, i_cdb_value,
        output i_eu_busy,
        input  o_disp_ready,
        input  o_ex_en, o_rob_addr, o_rs1_value, o_rs2_value, o_alu_m_opcode,
        input  o_count
    );
endinterface

// File: rtl/mul_reservation_station.sv
// ---------------------------------------------------------------------------
// mul_reservation_station
//
// Reservation station for the RV32M multiply/divide unit. Entries live in a
// collapsing queue (slot 0 = oldest, valid slots contiguous from 0). Operands
// not yet available wait on a producer ROB tag and are captured from the CDB.
// Each cycle the lowest-index entry with both operands ready is issued to the
// execution unit when it is not busy; the queue then collapses over that slot.
//
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset
//   rs    - mul_reservation_station_if.slave: flush, dispatch, CDB snoop,
//           eu busy, issue bus (o_ex_en + data) and occupancy count
// ---------------------------------------------------------------------------
module mul_reservation_station #(
    parameter int ROBSIZE = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    mul_reservation_station_if.slave rs
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic               valid;
        logic [ROBSIZE-1:0] rob_addr;
        logic [2:0]         opcode;
        logic               rs1_ready;
        logic [31:0]        rs1_value;
        logic [ROBSIZE-1:0] rs1_tag;
        logic               rs2_ready;
        logic [31:0]        rs2_value;
        logic [ROBSIZE-1:0] rs2_tag;
    } entry_t;

    entry_t             slots_q [DEPTH];
    entry_t             slots_d [DEPTH];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    // Current slots with this cycle's CDB capture applied; the extra empty
    // element at index DEPTH is what the top slot shifts in on a collapse.
    entry_t             woke [DEPTH+1];
    entry_t             disp_entry;

    logic               cand_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               issue;
    logic               disp_acc;
    logic [CNT_W-1:0]   wr_idx;

    // ---------------------------------------------------------------- select
    // Registered ready flags only: an entry woken this cycle waits one cycle.
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cand_found = 1'b0;
        sel_idx    = '0;
        // Walk downward so the lowest eligible index is the one left standing.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots_q[i].valid && slots_q[i].rs1_ready && slots_q[i].rs2_ready) begin
                cand_found = 1'b1;
                sel_idx    = IDX_W'(i);
            end
        end
    end

    assign issue           = cand_found & ~rs.i_eu_busy & ~rs.i_flush;
    // Full stalls dispatch even when an issue frees a slot this same cycle.
    assign rs.o_disp_ready = (count_q < CNT_W'(DEPTH));
    assign disp_acc        = rs.i_disp_valid & rs.o_disp_ready & ~rs.i_flush;
    // Dispatch lands just past the last valid slot after the collapse.
    assign wr_idx          = count_q - CNT_W'(issue);
    assign rs.o_count      = count_q;

    // ----------------------------------------------------------- issue bus
    always_comb begin
        rs.o_ex_en        = issue;
        rs.o_rob_addr     = '0;
        rs.o_rs1_value    = '0;
        rs.o_rs2_value    = '0;
        rs.o_alu_m_opcode = '0;
        if (issue) begin
            rs.o_rob_addr     = slots_q[sel_idx].rob_addr;
            rs.o_rs1_value    = slots_q[sel_idx].rs1_value;
            rs.o_rs2_value    = slots_q[sel_idx].rs2_value;
            rs.o_alu_m_opcode = slots_q[sel_idx].opcode;
        end
    end

    // --------------------------------------------------------------- wake-up
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = slots_q[i];
            if (rs.i_cdb_valid && slots_q[i].valid) begin
                if (!slots_q[i].rs1_ready && (slots_q[i].rs1_tag == rs.i_cdb_rob_addr)) begin
                    woke[i].rs1_ready = 1'b1;
                    woke[i].rs1_value = rs.i_cdb_value;
                end
                if (!slots_q[i].rs2_ready && (slots_q[i].rs2_tag == rs.i_cdb_rob_addr)) begin
                    woke[i].rs2_ready = 1'b1;
                    woke[i].rs2_value = rs.i_cdb_value;
                end
            end
        end
        woke[DEPTH] = '0;
    end

    // ------------------------------------------- dispatch entry with bypass
    // A producer broadcasting in the dispatch cycle would otherwise be missed.
    always_comb begin
        disp_entry.valid     = 1'b1;
        disp_entry.rob_addr  = rs.i_disp_rob_addr;
        disp_entry.opcode    = rs.i_disp_opcode;
        disp_entry.rs1_ready = rs.i_disp_rs1_ready;
        disp_entry.rs1_value = rs.i_disp_rs1_value;
        disp_entry.rs1_tag   = rs.i_disp_rs1_tag;
        disp_entry.rs2_ready = rs.i_disp_rs2_ready;
        disp_entry.rs2_value = rs.i_disp_rs2_value;
        disp_entry.rs2_tag   = rs.i_disp_rs2_tag;
        if (!rs.i_disp_rs1_ready && rs.i_cdb_valid && (rs.i_disp_rs1_tag == rs.i_cdb_rob_addr)) begin
            disp_entry.rs1_ready = 1'b1;
            disp_entry.rs1_value = rs.i_cdb_value;
        end
        if (!rs.i_disp_rs2_ready && rs.i_cdb_valid && (rs.i_disp_rs2_tag == rs.i_cdb_rob_addr)) begin
            disp_entry.rs2_ready = 1'b1;
            disp_entry.rs2_value = rs.i_cdb_value;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            // Slots at or above the issued one move down by one.
            slots_d[i] = (issue && (IDX_W'(i) >= sel_idx)) ? woke[i+1] : woke[i];
            if (disp_acc && (CNT_W'(i) == wr_idx)) begin
                slots_d[i] = disp_entry;
            end
        end
        count_d = count_q + CNT_W'(disp_acc) - CNT_W'(issue);

        // Flush wins over dispatch, issue and wake-up; payloads are don't-care.
        if (rs.i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_d[i].valid = 1'b0;
            end
            count_d = '0;
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: the whole entry array is reset, not just the valid bits, so the
    // stored payloads never carry X into the issue mux or into wake-up compares.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            slots_q <= slots_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mul_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_mul_reservation_station
//
// Directed bench for mul_reservation_station. Stimulus pushes the expected
// issue (rob, opcode, rs1, rs2) into a scoreboard queue in hand-computed issue
// order; a monitor on the falling edge pops and compares whenever o_ex_en is
// high, and flags any issue with an empty queue. Directed checks cover timing,
// occupancy, full-stall, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_mul_reservation_station;

    localparam int ROBSIZE = 8;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [ROBSIZE-1:0] rob;
        logic [2:0]         op;
        logic [31:0]        a;
        logic [31:0]        b;
    } exp_t;

    logic clk;
    logic rstn;

    mul_reservation_station_if #(.ROBSIZE(ROBSIZE), .DEPTH(DEPTH)) rs_if ();

    mul_reservation_station #(.ROBSIZE(ROBSIZE), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rs   (rs_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] rob, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.rob = rob; e.op = op; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic set_disp(input logic [7:0] rob, input logic [2:0] op,
                            input logic r1_rdy, input logic [31:0] r1_val, input logic [7:0] r1_tag,
                            input logic r2_rdy, input logic [31:0] r2_val, input logic [7:0] r2_tag);
        rs_if.i_disp_valid     = 1'b1;
        rs_if.i_disp_rob_addr  = rob;
        rs_if.i_disp_opcode    = op;
        rs_if.i_disp_rs1_ready = r1_rdy;
        rs_if.i_disp_rs1_value = r1_val;
        rs_if.i_disp_rs1_tag   = r1_tag;
        rs_if.i_disp_rs2_ready = r2_rdy;
        rs_if.i_disp_rs2_value = r2_val;
        rs_if.i_disp_rs2_tag   = r2_tag;
    endtask

    task automatic clear_disp();
        rs_if.i_disp_valid = 1'b0;
    endtask

    task automatic set_cdb(input logic [7:0] tag, input logic [31:0] val);
        rs_if.i_cdb_valid    = 1'b1;
        rs_if.i_cdb_rob_addr = tag;
        rs_if.i_cdb_value    = val;
    endtask

    task automatic clear_cdb();
        rs_if.i_cdb_valid = 1'b0;
    endtask

    // Monitor: compares every issue against the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            if (rs_if.o_ex_en) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: rob 0x%0h issued, none expected (t=%0t)",
                             rs_if.o_rob_addr, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("issue_rob",    64'(rs_if.o_rob_addr),     64'(mon_e.rob));
                    check("issue_opcode", 64'(rs_if.o_alu_m_opcode), 64'(mon_e.op));
                    check("issue_rs1",    64'(rs_if.o_rs1_value),    64'(mon_e.a));
                    check("issue_rs2",    64'(rs_if.o_rs2_value),    64'(mon_e.b));
                end
            end else begin
                check("idle_outputs_zero",
                      64'(|{rs_if.o_rob_addr, rs_if.o_alu_m_opcode, rs_if.o_rs1_value, rs_if.o_rs2_value}),
                      64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        rs_if.i_flush = 1'b0;
        rs_if.i_eu_busy = 1'b0;
        clear_cdb();
        rs_if.i_cdb_rob_addr = '0;
        rs_if.i_cdb_value = '0;
        set_disp(8'd0, 3'd0, 1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        clear_disp();

        // ---- reset state
        #12;
        check("rst_count",      64'(rs_if.o_count),        64'd0);
        check("rst_disp_ready", 64'(rs_if.o_disp_ready),   64'd1);
        check("rst_ex_en",      64'(rs_if.o_ex_en),        64'd0);
        check("rst_data_zero",
              64'(|{rs_if.o_rob_addr, rs_if.o_alu_m_opcode, rs_if.o_rs1_value, rs_if.o_rs2_value}),
              64'd0);
        rstn = 1'b1;

        // ---- 1: MUL, both ready, issue next cycle
        set_disp(8'd1, 3'b000, 1'b1, 32'd3, 8'd0, 1'b1, 32'd5, 8'd0);
        push(8'd1, 3'b000, 32'd3, 32'd5);
        tick();
        clear_disp();
        at_neg();
        check("t1_issue_next_cycle", 64'(rs_if.o_ex_en), 64'd1);
        check("t1_count_one",        64'(rs_if.o_count), 64'd1);
        tick();
        check("t1_count_zero",       64'(rs_if.o_count), 64'd0);

        // ---- 2: DIV waiting on tag 6, CDB two cycles later
        set_disp(8'd2, 3'b100, 1'b1, 32'd10, 8'd0, 1'b0, 32'd0, 8'd6);
        push(8'd2, 3'b100, 32'd10, 32'd7);
        tick();
        clear_disp();
        at_neg();
        check("t2_blocked_a", 64'(rs_if.o_ex_en), 64'd0);
        tick();
        set_cdb(8'd6, 32'd7);
        at_neg();
        check("t2_blocked_b", 64'(rs_if.o_ex_en), 64'd0);
        tick();
        clear_cdb();
        at_neg();
        check("t2_issue_after_cdb", 64'(rs_if.o_ex_en), 64'd1);
        tick();
        check("t2_count_zero", 64'(rs_if.o_count), 64'd0);

        // ---- 3: younger ready entry overtakes older blocked one
        set_disp(8'd3, 3'b001, 1'b0, 32'd0, 8'd9, 1'b1, 32'd2, 8'd0);
        tick();
        set_disp(8'd4, 3'b011, 1'b1, 32'd6, 8'd0, 1'b1, 32'd7, 8'd0);
        push(8'd4, 3'b011, 32'd6, 32'd7);
        push(8'd3, 3'b001, 32'h11, 32'd2);
        at_neg();
        check("t3_old_blocked", 64'(rs_if.o_ex_en), 64'd0);
        tick();
        clear_disp();
        at_neg();
        check("t3_young_first", 64'(rs_if.o_ex_en), 64'd1);
        tick();
        check("t3_count_one", 64'(rs_if.o_count), 64'd1);
        set_cdb(8'd9, 32'h11);
        at_neg();
        check("t3_wake_not_same_cycle", 64'(rs_if.o_ex_en), 64'd0);
        tick();
        clear_cdb();
        at_neg();
        check("t3_old_after_wake", 64'(rs_if.o_ex_en), 64'd1);
        tick();
        check("t3_count_zero", 64'(rs_if.o_count), 64'd0);

        // ---- 4: fill while busy, 5th dispatch ignored, drain in order
        rs_if.i_eu_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_disp(8'(10 + k), 3'(k), 1'b1, 32'(100 + k), 8'd0, 1'b1, 32'(200 + k), 8'd0);
            push(8'(10 + k), 3'(k), 32'(100 + k), 32'(200 + k));
            tick();
        end
        clear_disp();
        check("t4_count_full",  64'(rs_if.o_count),      64'd4);
        check("t4_ready_low",   64'(rs_if.o_disp_ready), 64'd0);
        set_disp(8'd14, 3'b111, 1'b1, 32'd1, 8'd0, 1'b1, 32'd1, 8'd0);
        tick();
        clear_disp();
        check("t4_fifth_ignored", 64'(rs_if.o_count), 64'd4);
        for (int k = 0; k < 4; k++) begin
            rs_if.i_eu_busy = 1'b0;
            at_neg();
            check("t4_strobe_on_idle", 64'(rs_if.o_ex_en), 64'd1);
            tick();
            rs_if.i_eu_busy = 1'b1;
            at_neg();
            check("t4_no_strobe_busy", 64'(rs_if.o_ex_en), 64'd0);
            tick();
        end
        rs_if.i_eu_busy = 1'b0;
        check("t4_count_zero", 64'(rs_if.o_count), 64'd0);

        // ---- 5: dispatch bypass from same-cycle CDB
        set_disp(8'd20, 3'b101, 1'b0, 32'd0, 8'd5, 1'b1, 32'd3, 8'd0);
        set_cdb(8'd5, 32'hDEADBEEF);
        push(8'd20, 3'b101, 32'hDEADBEEF, 32'd3);
        tick();
        clear_disp();
        clear_cdb();
        at_neg();
        check("t5_bypass_issue", 64'(rs_if.o_ex_en), 64'd1);
        tick();
        check("t5_count_zero", 64'(rs_if.o_count), 64'd0);

        // ---- 6: flush with concurrent dispatch and ready candidate
        rs_if.i_eu_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_disp(8'(30 + k), 3'b000, 1'b1, 32'd1, 8'd0, 1'b1, 32'd1, 8'd0);
            tick();
        end
        clear_disp();
        check("t6_count_three", 64'(rs_if.o_count), 64'd3);
        rs_if.i_eu_busy = 1'b0;
        rs_if.i_flush = 1'b1;
        set_disp(8'd33, 3'b000, 1'b1, 32'd2, 8'd0, 1'b1, 32'd2, 8'd0);
        at_neg();
        check("t6_flush_blocks_issue", 64'(rs_if.o_ex_en), 64'd0);
        tick();
        rs_if.i_flush = 1'b0;
        clear_disp();
        check("t6_count_zero",   64'(rs_if.o_count),      64'd0);
        check("t6_ready_high",   64'(rs_if.o_disp_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            tick();
        end

        // ---- 7: asynchronous reset mid-operation
        rs_if.i_eu_busy = 1'b1;
        set_disp(8'd40, 3'b010, 1'b1, 32'd4, 8'd0, 1'b1, 32'd4, 8'd0);
        tick();
        set_disp(8'd41, 3'b010, 1'b1, 32'd5, 8'd0, 1'b1, 32'd5, 8'd0);
        tick();
        clear_disp();
        check("t7_count_two", 64'(rs_if.o_count), 64'd2);
        rstn = 1'b0;
        rs_if.i_eu_busy = 1'b0;
        #1;
        check("t7_rst_ex_en",      64'(rs_if.o_ex_en),      64'd0);
        check("t7_rst_count",      64'(rs_if.o_count),      64'd0);
        check("t7_rst_disp_ready", 64'(rs_if.o_disp_ready), 64'd1);
        check("t7_rst_data_zero",
              64'(|{rs_if.o_rob_addr, rs_if.o_alu_m_opcode, rs_if.o_rs1_value, rs_if.o_rs2_value}),
              64'd0);
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            tick();
        end
        check("t7_count_after", 64'(rs_if.o_count), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_reservation_station.md
# mul_reservation_station

Reservation station for the RV32M multiply/divide execution unit. It buffers dispatched M-extension instructions, wakes operands by snooping the common data bus (CDB), and issues the oldest fully-ready entry to the MUL/DIV control unit whenever that unit reports not busy. It sits directly upstream of the MUL/DIV control unit, driving its `ex_en`, `rob_addr`, `rs1_value`, `rs2_value` and `alu_m_opcode` inputs and consuming its `busy` output.

## Interface
- ROBSIZE, 8: width of a ROB tag, matching the execution unit's rob-addr width.
- DEPTH, 4: number of entries (2..8).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- i_flush  in  1  pipeline flush; discards all entries.
- i_disp_valid  in  1  dispatch request.
- o_disp_ready  out  1  an entry is free; the entry is accepted when valid&ready&~flush.
- i_disp_rob_addr  in  ROBSIZE  ROB tag of the instruction.
- i_disp_opcode  in  3  funct3 (000 MUL .. 111 REMU).
- i_disp_rs1_ready, i_disp_rs2_ready  in  1  operand value already available.
- i_disp_rs1_value, i_disp_rs2_value  in  32  operand value (valid when ready).
- i_disp_rs1_tag, i_disp_rs2_tag  in  ROBSIZE  producer ROB tag (used when not ready).
- i_cdb_valid  in  1  CDB broadcast this cycle.
- i_cdb_rob_addr  in  ROBSIZE  broadcast producer tag.
- i_cdb_value  in  32  broadcast result.
- i_eu_busy  in  1  execution unit busy (unit's o_busy).
- o_ex_en  out  1  issue strobe to the unit.
- o_rob_addr  out  ROBSIZE  issued ROB tag.
- o_rs1_value, o_rs2_value  out  32  issued operands.
- o_alu_m_opcode  out  3  issued funct3.
- o_count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a collapsing queue. Slot 0 holds the oldest entry, and valid slots are always contiguous from 0. Each slot holds: valid, rob_addr, opcode, and for each of rs1/rs2 a ready flag, a 32-bit value and a tag.
- Dispatch: an accepted instruction is written at slot index (count − issued_this_cycle).
- Dispatch bypass: if a dispatched operand is not ready and i_cdb_valid is high with i_cdb_rob_addr equal to its tag in the same cycle, it is stored ready with i_cdb_value.
- Wake-up: on every cycle with i_cdb_valid, each valid entry's not-ready operand whose tag matches captures i_cdb_value and sets ready. Multiple entries may wake on one broadcast.
- Select: the candidate is the lowest-index slot with valid & rs1_ready & rs2_ready, using registered flags only. An entry woken this cycle becomes eligible next cycle.
- Issue: o_ex_en = candidate_exists & ~i_eu_busy & ~i_flush. When asserted, the o_* data outputs carry the candidate's fields. The entry is removed at the clock edge and higher slots shift down by one.
- o_* data outputs are combinational from the selected slot and are 0 when o_ex_en=0.
- Out-of-order issue is allowed: a younger ready entry issues ahead of an older blocked one.
- o_disp_ready = (count < DEPTH). It does not depend on same-cycle issue. Full state therefore stalls dispatch even if an issue occurs.
- Flush: when i_flush is high, all valid bits clear at the edge, o_ex_en is forced 0, dispatch is not accepted, and CDB capture is irrelevant.
- Count: count_next = count + dispatch_accepted − issued. Count never exceeds DEPTH and never underflows.

## Timing
- Reset (async): all valid bits 0, o_count=0, o_disp_ready=1, o_ex_en=0, all o_* data outputs 0.
- Minimum dispatch-to-issue latency with both operands ready at dispatch: dispatch at edge N, o_ex_en high in cycle N+1 if the unit is idle.
- CDB wake-up latency: a broadcast captured at edge N makes the entry eligible in cycle N+1.
- One issue per cycle at most. The unit raises busy the cycle after accepting an issue, so back-to-back issue occurs only if the unit is idle again.
- Simultaneous dispatch + issue + CDB in one cycle: all three take effect at the same edge. Slot indices are computed after the collapse.
- Flush has priority over dispatch, issue and wake-up.

## Test plan
- Dispatch MUL rob=1 rs1=3 rs2=5, both ready, eu idle -> next cycle o_ex_en=1, o_rob_addr=1, values 3/5, opcode 000; o_count returns to 0.
- Dispatch DIV rob=2 with rs2 waiting on tag 6; CDB tag 6 value 7 two cycles later -> issue exactly one cycle after the broadcast, o_rs2_value=7.
- Dispatch rob 3 (blocked on tag 9), then rob 4 (ready) -> rob 4 issues first. After CDB tag 9, rob 3 issues.
- Fill 4 entries with eu_busy=1 -> o_disp_ready=0 and a 5th dispatch is ignored. Release busy -> issue in order 0,1,2,3 with one strobe each time busy drops.
- Dispatch with rs1 tag 5 not ready while CDB broadcasts tag 5 value 0xDEADBEEF in the same cycle -> entry issues next cycle with rs1=0xDEADBEEF.
- With 3 entries queued, assert i_flush with a concurrent dispatch and ready candidate -> o_ex_en=0 in that cycle, o_count=0 after the edge, no issue afterwards. Assert rstn low mid-operation -> all outputs take their reset values immediately.
